unidade_controle: RTL and testbench
===================================

# unidade_controle

Multicycle control unit for the RISC-V datapath. It generates the 4-bit `estado` that drives instruction fetch (fetch state = 4'b0000) and decodes the fetched instruction. It then sequences the per-state control strobes for the register file, ALU, data memory and PC. It also counts retired instructions and halts on unsupported encodings.

## Interface
Parameters:
- `LARG_CONT`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instrucao`  in  32  current instruction word from the fetch unit; valid while `estado` = DECODIFICA.
- `zero`  in  1  ALU zero flag; sampled combinationally in DESVIO.
- `estado`  out  4  current FSM state (registered).
- `pc_escreve`  out  1  PC update strobe; PC increments by 1 (word index) or loads the branch target.
- `pc_desvio`  out  1  selects the branch target for the PC update.
- `reg_escreve`  out  1  register-file write enable.
- `mem_le`  out  1  data-memory read enable.
- `mem_escreve`  out  1  data-memory write enable.
- `mem_para_reg`  out  1  write-back mux: 1 = memory data, 0 = ALU result.
- `ula_src`  out  1  ALU B operand: 1 = immediate, 0 = rs2.
- `ula_op`  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
- `parado`  out  1  high while in PARADO.
- `instr_count`  out  LARG_CONT  number of retired instructions; saturates at all-ones.

## Operation
- State encodings:
  - BUSCA 0000, DECODIFICA 0001, CALC_END 0010, LE_MEM 0011, ESCREVE_LOAD 0100, ESCREVE_MEM 0101.
  - EXECUTA_R 0110, ESCREVE_R 0111, EXECUTA_I 1000, ESCREVE_I 1001, DESVIO 1010, PARADO 1111.
  - Unused codes go to PARADO.
- Sequences:
  - BUSCA always goes to DECODIFICA.
  - lw (opcode 0000011, f3 010): CALC_END -> LE_MEM -> ESCREVE_LOAD -> BUSCA.
  - sw (0100011, f3 010): CALC_END -> ESCREVE_MEM -> BUSCA.
  - R-type (0110011): EXECUTA_R -> ESCREVE_R -> BUSCA.
  - I-type ALU (0010011): EXECUTA_I -> ESCREVE_I -> BUSCA.
  - Branch (1100011): DESVIO -> BUSCA.
- DECODIFICA latches opcode, funct3 and funct7[5] into internal registers. Later states use only the latched copy.
- Supported functions:
  - R-type: add (f3 000, f7 0000000), sub (f3 000, f7 0100000), and (f3 111), or (f3 110).
  - I-type: addi (000), andi (111), ori (110).
  - Branch: beq (000), bne (001).
- Any other opcode or funct combination, or `instrucao` = 0, goes from DECODIFICA to PARADO.
- PARADO is terminal until `rst_n` is asserted.
- Outputs are Moore decodes of the state, except `pc_desvio`. Any output not listed below is 0 in that state.
  - BUSCA, DECODIFICA, PARADO: all strobes 0.
  - CALC_END and LE_MEM: `ula_src`=1, `ula_op`=ADD. LE_MEM also drives `mem_le`=1.
  - ESCREVE_LOAD: `reg_escreve`=1, `mem_para_reg`=1, `pc_escreve`=1.
  - ESCREVE_MEM: `mem_escreve`=1, `ula_src`=1, `ula_op`=ADD, `pc_escreve`=1.
  - EXECUTA_R and ESCREVE_R: `ula_op` from the decoded function. ESCREVE_R also drives `reg_escreve`=1 and `pc_escreve`=1.
  - EXECUTA_I and ESCREVE_I: `ula_src`=1, `ula_op` decoded. ESCREVE_I also drives `reg_escreve`=1 and `pc_escreve`=1.
  - DESVIO: `ula_op`=SUB, `pc_escreve`=1.
- `pc_desvio` = (state==DESVIO) && ((beq && `zero`) || (bne && !`zero`)).
- `instr_count` increments on every rising edge where `pc_escreve`=1. It holds at 2^LARG_CONT-1.

## Timing
- Reset (async, while `rst_n`=0): `estado`=0000, latched fields=0, `instr_count`=0, all strobes 0, `parado`=0.
- The first BUSCA cycle is the one after reset release. The fetch unit loads `instrucao` at that edge, so the instruction is valid in DECODIFICA.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, branch 3. Each count includes BUSCA and DECODIFICA.
- `pc_escreve` is a single-cycle pulse in the last state of every instruction. The PC changes at the edge that leaves that state, i.e. the same edge that enters BUSCA.
- `zero` must be stable within DESVIO. Its value in any other state is ignored.
- Reset asserted mid-instruction aborts immediately. No pending write strobe survives, and the count does not advance for the aborted instruction.
- Entering PARADO does not change `instr_count`. `parado` rises in the first PARADO cycle.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release -> `estado`=0000, then 0001 one cycle later; `instr_count`=0; all strobes 0.
- add x3,x1,x2 (32'h002081B3) -> states 0,1,6,7,0. In state 7 `reg_escreve`=1, `pc_escreve`=1, `ula_op`=0000. `instr_count` goes 0->1.
- lw x5,4(x0) (32'h00402283) -> states 0,1,2,3,4,0. `mem_le`=1 only in state 3; `mem_para_reg`=`reg_escreve`=1 only in state 4.
- beq (32'h00208463) with `zero`=1 -> `pc_desvio`=1 in state 1010. Repeat with `zero`=0 -> `pc_desvio`=0, `pc_escreve`=1. For bne (32'h00209463) the results invert.
- Invalid instruction 32'hFFFFFFFF and also 32'h00000000 -> state 1111, `parado`=1 for 10 cycles; no strobes; count unchanged.
- `rst_n` pulsed low during LE_MEM -> `estado`=0000 immediately, `mem_le`=0, `instr_count`=0. The next instruction executes normally.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle RISC-V control unit: fetch/decode FSM, per-state control strobes,
// retired-instruction counter and halt on unsupported encodings.
module unidade_controle #(
   parameter int LARG_CONT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          instrucao,
   input  logic                 zero,
   output logic [3:0]           estado,
   output logic                 pc_escreve,
   output logic                 pc_desvio,
   output logic                 reg_escreve,
   output logic                 mem_le,
   output logic                 mem_escreve,
   output logic                 mem_para_reg,
   output logic                 ula_src,
   output logic [3:0]           ula_op,
   output logic                 parado,
   output logic [LARG_CONT-1:0] instr_count
);

   typedef enum logic [3:0] {
      BUSCA        = 4'b0000,
      DECODIFICA   = 4'b0001,
      CALC_END     = 4'b0010,
      LE_MEM       = 4'b0011,
      ESCREVE_LOAD = 4'b0100,
      ESCREVE_MEM  = 4'b0101,
      EXECUTA_R    = 4'b0110,
      ESCREVE_R    = 4'b0111,
      EXECUTA_I    = 4'b1000,
      ESCREVE_I    = 4'b1001,
      DESVIO       = 4'b1010,
      PARADO       = 4'b1111
   } estado_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   localparam logic [3:0] ULA_ADD = 4'b0000;
   localparam logic [3:0] ULA_SUB = 4'b0001;
   localparam logic [3:0] ULA_AND = 4'b0010;
   localparam logic [3:0] ULA_OR  = 4'b0011;

   localparam logic [LARG_CONT-1:0] UM = LARG_CONT'(1);

   estado_t    est, prox, dec_prox;
   logic [6:0] opcode_r;
   logic [2:0] f3_r;
   logic       f7b5_r;
   logic [3:0] op_dec;

   logic [6:0] opc_in;
   logic [2:0] f3_in;
   logic [6:0] f7_in;

   assign opc_in = instrucao[6:0];
   assign f3_in  = instrucao[14:12];
   assign f7_in  = instrucao[31:25];

   // Decode of the live instruction word; only consulted in DECODIFICA.
   always_comb begin
      dec_prox = PARADO;
      if (instrucao != '0) begin
         case (opc_in)
            OP_LW, OP_SW:
               if (f3_in == 3'b010) dec_prox = CALC_END;
            OP_R:
               if ((f3_in == 3'b000 && (f7_in == 7'b0000000 || f7_in == 7'b0100000)) ||
                   f3_in == 3'b111 || f3_in == 3'b110)
                  dec_prox = EXECUTA_R;
            OP_I:
               if (f3_in == 3'b000 || f3_in == 3'b111 || f3_in == 3'b110)
                  dec_prox = EXECUTA_I;
            OP_BR:
               if (f3_in == 3'b000 || f3_in == 3'b001) dec_prox = DESVIO;
            default: dec_prox = PARADO;
         endcase
      end
   end

   // funct7[5] selects SUB only for R-type; for I-type it is an immediate bit.
   always_comb begin
      op_dec = ULA_ADD;
      case (f3_r)
         3'b000:  op_dec = (opcode_r == OP_R && f7b5_r) ? ULA_SUB : ULA_ADD;
         3'b111:  op_dec = ULA_AND;
         3'b110:  op_dec = ULA_OR;
         default: op_dec = ULA_ADD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         est         <= BUSCA;
         opcode_r    <= '0;
         f3_r        <= '0;
         f7b5_r      <= 1'b0;
         instr_count <= '0;
      end else begin
         est <= prox;
         if (est == DECODIFICA) begin
            opcode_r <= opc_in;
            f3_r     <= f3_in;
            f7b5_r   <= f7_in[5];
         end
         if (pc_escreve && instr_count != '1)
            instr_count <= instr_count + UM;
      end
   end

   always_comb begin
      prox         = PARADO;
      pc_escreve   = 1'b0;
      pc_desvio    = 1'b0;
      reg_escreve  = 1'b0;
      mem_le       = 1'b0;
      mem_escreve  = 1'b0;
      mem_para_reg = 1'b0;
      ula_src      = 1'b0;
      ula_op       = ULA_ADD;
      parado       = 1'b0;
      case (est)
         BUSCA:      prox = DECODIFICA;
         DECODIFICA: prox = dec_prox;
         CALC_END: begin
            prox    = (opcode_r == OP_SW) ? ESCREVE_MEM : LE_MEM;
            ula_src = 1'b1;
         end
         LE_MEM: begin
            prox    = ESCREVE_LOAD;
            ula_src = 1'b1;
            mem_le  = 1'b1;
         end
         ESCREVE_LOAD: begin
            prox         = BUSCA;
            reg_escreve  = 1'b1;
            mem_para_reg = 1'b1;
            pc_escreve   = 1'b1;
         end
         ESCREVE_MEM: begin
            prox        = BUSCA;
            mem_escreve = 1'b1;
            ula_src     = 1'b1;
            pc_escreve  = 1'b1;
         end
         EXECUTA_R: begin
            prox   = ESCREVE_R;
            ula_op = op_dec;
         end
         ESCREVE_R: begin
            prox        = BUSCA;
            ula_op      = op_dec;
            reg_escreve = 1'b1;
            pc_escreve  = 1'b1;
         end
         EXECUTA_I: begin
            prox    = ESCREVE_I;
            ula_src = 1'b1;
            ula_op  = op_dec;
         end
         ESCREVE_I: begin
            prox        = BUSCA;
            ula_src     = 1'b1;
            ula_op      = op_dec;
            reg_escreve = 1'b1;
            pc_escreve  = 1'b1;
         end
         DESVIO: begin
            prox       = BUSCA;
            ula_op     = ULA_SUB;
            pc_escreve = 1'b1;
            pc_desvio  = (f3_r == 3'b000 && zero) || (f3_r == 3'b001 && !zero);
         end
         PARADO: begin
            prox   = PARADO;
            parado = 1'b1;
         end
         default: prox = PARADO;
      endcase
   end

   assign estado = est;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed vector table, reset/abort
// and saturation sequences, and randomized instructions against a class model.
module tb_unidade_controle;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   instrucao = '0;
   logic          zero = 1'b0;
   logic [3:0]    estado;
   logic          pc_escreve, pc_desvio, reg_escreve, mem_le, mem_escreve;
   logic          mem_para_reg, ula_src, parado;
   logic [3:0]    ula_op;
   logic [W-1:0]  instr_count;

   always #5 clk = ~clk;

   unidade_controle #(.LARG_CONT(W)) dut (
      .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .zero(zero),
      .estado(estado), .pc_escreve(pc_escreve), .pc_desvio(pc_desvio),
      .reg_escreve(reg_escreve), .mem_le(mem_le), .mem_escreve(mem_escreve),
      .mem_para_reg(mem_para_reg), .ula_src(ula_src), .ula_op(ula_op),
      .parado(parado), .instr_count(instr_count)
   );

   int n_pass = 0;
   int n_tot  = 0;
   int unsigned model_cnt = 0;

   typedef enum {C_LW, C_SW, C_R, C_I, C_B, C_BAD} cls_t;
   typedef struct {logic [3:0] st; logic [11:0] vec;} cyc_t;
   typedef struct {logic [31:0] ins; logic z; int cyc; logic [3:0] op; logic desv;} vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [11:0] outs();
      return {pc_escreve, pc_desvio, reg_escreve, mem_le, mem_escreve,
              mem_para_reg, ula_src, ula_op, parado};
   endfunction

   function automatic logic [11:0] v(input logic pcw, pcd, rw, ml, mw, mr, us,
                                     input logic [3:0] op, input logic pa);
      return {pcw, pcd, rw, ml, mw, mr, us, op, pa};
   endfunction

   // Instruction-level reference: class, ALU function, branch sense.
   function automatic void classify(input logic [31:0] ins, output cls_t c,
                                    output logic [3:0] op, output logic isbne);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      c = C_BAD; op = 4'd0; isbne = 1'b0;
      if (opc == 7'h03 && f3 == 3'd2) c = C_LW;
      else if (opc == 7'h23 && f3 == 3'd2) c = C_SW;
      else if (opc == 7'h33) begin
         if (f3 == 3'd0 && f7 == 7'h00) begin c = C_R; op = 4'd0; end
         else if (f3 == 3'd0 && f7 == 7'h20) begin c = C_R; op = 4'd1; end
         else if (f3 == 3'd7) begin c = C_R; op = 4'd2; end
         else if (f3 == 3'd6) begin c = C_R; op = 4'd3; end
      end else if (opc == 7'h13) begin
         if (f3 == 3'd0) begin c = C_I; op = 4'd0; end
         else if (f3 == 3'd7) begin c = C_I; op = 4'd2; end
         else if (f3 == 3'd6) begin c = C_I; op = 4'd3; end
      end else if (opc == 7'h63) begin
         if (f3 == 3'd0) c = C_B;
         else if (f3 == 3'd1) begin c = C_B; isbne = 1'b1; end
      end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_estado", 32'(estado), 32'h0);
      check("rst_outs", 32'(outs()), 32'h0);
      check("rst_count", 32'(instr_count), 32'h0);
      rst_n = 1'b1;
      #1;
      check("rel_estado", 32'(estado), 32'h0);
      model_cnt = 0;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic z, output int cyc,
                            output logic [3:0] op2, output logic desv);
      cls_t c;
      logic [3:0] op;
      logic bne;
      cyc_t q[$];
      classify(ins, c, op, bne);
      q.push_back('{4'h0, 12'h0});
      q.push_back('{4'h1, 12'h0});
      case (c)
         C_LW: begin
            q.push_back('{4'h2, v(0,0,0,0,0,0,1,4'd0,0)});
            q.push_back('{4'h3, v(0,0,0,1,0,0,1,4'd0,0)});
            q.push_back('{4'h4, v(1,0,1,0,0,1,0,4'd0,0)});
         end
         C_SW: begin
            q.push_back('{4'h2, v(0,0,0,0,0,0,1,4'd0,0)});
            q.push_back('{4'h5, v(1,0,0,0,1,0,1,4'd0,0)});
         end
         C_R: begin
            q.push_back('{4'h6, v(0,0,0,0,0,0,0,op,0)});
            q.push_back('{4'h7, v(1,0,1,0,0,0,0,op,0)});
         end
         C_I: begin
            q.push_back('{4'h8, v(0,0,0,0,0,0,1,op,0)});
            q.push_back('{4'h9, v(1,0,1,0,0,0,1,op,0)});
         end
         C_B: q.push_back('{4'hA, v(1, bne ? !z : z, 0,0,0,0,0,4'd1,0)});
         default: for (int k = 0; k < 10; k++) q.push_back('{4'hF, v(0,0,0,0,0,0,0,4'd0,1)});
      endcase
      instrucao = ins;
      op2 = 4'd0;
      desv = 1'b0;
      foreach (q[i]) begin
         zero = (q[i].st == 4'hA) ? z : 1'($urandom);
         #1;
         check("estado", 32'(estado), 32'(q[i].st));
         check("outs", 32'(outs()), 32'(q[i].vec));
         if (i == 2) op2 = ula_op;
         desv = desv | pc_desvio;
         @(posedge clk);
         #1;
         if (i == 1) instrucao = $urandom;
      end
      cyc = q.size();
      if (c == C_BAD) begin
         check("halt_estado", 32'(estado), 32'hF);
         check("halt_count", 32'(instr_count), 32'(model_cnt));
         do_reset();
      end else begin
         if (model_cnt < (1 << W) - 1) model_cnt++;
         check("next_busca", 32'(estado), 32'h0);
         check("count", 32'(instr_count), 32'(model_cnt));
      end
   endtask

   vec_t tbl[18];

   initial begin
      int cyc;
      logic [3:0] op2;
      logic desv;
      logic [6:0] opcs[5];

      tbl = '{
         '{32'h002081B3, 1'b0,  4, 4'd0, 1'b0},   // add
         '{32'h402081B3, 1'b0,  4, 4'd1, 1'b0},   // sub
         '{32'h0020F1B3, 1'b0,  4, 4'd2, 1'b0},   // and
         '{32'h0020E1B3, 1'b0,  4, 4'd3, 1'b0},   // or
         '{32'h00402283, 1'b0,  5, 4'd0, 1'b0},   // lw
         '{32'h00502223, 1'b0,  4, 4'd0, 1'b0},   // sw
         '{32'h00500093, 1'b0,  4, 4'd0, 1'b0},   // addi
         '{32'h00507093, 1'b0,  4, 4'd2, 1'b0},   // andi
         '{32'h00506093, 1'b0,  4, 4'd3, 1'b0},   // ori
         '{32'hFFF00093, 1'b0,  4, 4'd0, 1'b0},   // addi -1: imm bit30 is not SUB
         '{32'h00208463, 1'b1,  3, 4'd1, 1'b1},   // beq taken
         '{32'h00208463, 1'b0,  3, 4'd1, 1'b0},   // beq not taken
         '{32'h00209463, 1'b1,  3, 4'd1, 1'b0},   // bne not taken
         '{32'h00209463, 1'b0,  3, 4'd1, 1'b1},   // bne taken
         '{32'hFFFFFFFF, 1'b0, 12, 4'd0, 1'b0},   // invalid
         '{32'h00000000, 1'b0, 12, 4'd0, 1'b0},   // all-zero word
         '{32'h202081B3, 1'b0, 12, 4'd0, 1'b0},   // R-type bad funct7
         '{32'h00400283, 1'b0, 12, 4'd0, 1'b0}    // lb unsupported
      };
      opcs = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};

      do_reset();

      for (int t = 0; t < 18; t++) begin
         run_instr(tbl[t].ins, tbl[t].z, cyc, op2, desv);
         check($sformatf("tbl%0d_cycles", t), 32'(cyc), 32'(tbl[t].cyc));
         check($sformatf("tbl%0d_ulaop", t), 32'(op2), 32'(tbl[t].op));
         check($sformatf("tbl%0d_desvio", t), 32'(desv), 32'(tbl[t].desv));
      end

      // Abort a load in LE_MEM with reset
      do_reset();
      run_instr(32'h002081B3, 1'b0, cyc, op2, desv);
      instrucao = 32'h00402283;
      repeat (3) begin @(posedge clk); #1; end
      check("abort_in_lemem", 32'(estado), 32'h3);
      check("abort_memle_on", 32'(mem_le), 32'h1);
      rst_n = 1'b0;
      #1;
      check("abort_estado", 32'(estado), 32'h0);
      check("abort_memle", 32'(mem_le), 32'h0);
      check("abort_count", 32'(instr_count), 32'h0);
      do_reset();
      run_instr(32'h002081B3, 1'b0, cyc, op2, desv);
      check("after_abort_count", 32'(instr_count), 32'h1);

      // Counter saturation
      do_reset();
      for (int k = 0; k < 17; k++) run_instr(32'h00500093, 1'b0, cyc, op2, desv);
      check("saturated", 32'(instr_count), 32'd15);
      run_instr(32'h00208463, 1'b1, cyc, op2, desv);
      check("saturated_hold", 32'(instr_count), 32'd15);

      // Randomized instructions
      do_reset();
      for (int r = 0; r < 60; r++) begin
         logic [31:0] rnd, ins;
         logic [6:0] f7;
         logic [2:0] f3;
         rnd = $urandom;
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = rnd[31:25];
         endcase
         ins = {f7, rnd[24:15], f3, rnd[11:7], opcs[$urandom_range(0, 4)]};
         if ($urandom_range(0, 7) == 0) ins = $urandom;
         run_instr(ins, 1'($urandom), cyc, op2, desv);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
